// File: rtl/snitch_event_counter_bank.sv
// Programmable performance-counter bank: NumCounters counters, each summing the masked
// harts that raised a selected event, with wrap/saturate, sticky overflow, IRQ and snapshot.
module snitch_event_counter_bank #(
    parameter int unsigned NumCores     = 8,
    parameter int unsigned NumEvents    = 7,
    parameter int unsigned NumCounters  = 4,
    parameter int unsigned CounterWidth = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NumCores*NumEvents-1:0] events_i,
    input  logic                          reg_valid_i,
    output logic                          reg_ready_o,
    input  logic                          reg_write_i,
    input  logic [7:0]                    reg_addr_i,
    input  logic [31:0]                   reg_wdata_i,
    output logic                          reg_rvalid_o,
    output logic [31:0]                   reg_rdata_o,
    output logic                          irq_o
);
    localparam int unsigned IncWidth   = $clog2(NumCores + 1);
    localparam int unsigned SumWidth   = CounterWidth + 1;
    localparam int unsigned NumEvtBits = NumCores * NumEvents;
    localparam logic [7:0]  GlobalAddr = 8'(4 * NumCounters);

    logic [NumEvtBits-1:0]   events_r;
    logic [NumCounters-1:0]  en_r;
    logic [NumCounters-1:0]  sat_r;
    logic [NumCounters-1:0]  irq_en_r;
    logic [NumCounters-1:0]  ovf_r;
    logic [7:0]              evt_sel_r   [NumCounters];
    logic [NumCores-1:0]     mask_r      [NumCounters];
    logic [CounterWidth-1:0] value_r     [NumCounters];
    logic [CounterWidth-1:0] snap_r      [NumCounters];
    logic                    rvalid_r;
    logic [31:0]             rdata_r;
    logic                    irq_r;

    logic                    wr_s;
    logic                    rd_s;
    logic                    global_wr_s;
    logic                    snap_trig_s;
    logic                    clr_all_s;
    logic                    clr_ovf_s;
    logic [NumCounters-1:0]  addr_hit_s;
    logic [NumCounters-1:0]  cfg_we_s;
    logic [NumCounters-1:0]  mask_we_s;
    logic [NumCounters-1:0]  value_we_s;
    logic [IncWidth-1:0]     inc_s       [NumCounters];
    logic [SumWidth-1:0]     sum_s       [NumCounters];
    logic [CounterWidth-1:0] value_nxt_s [NumCounters];
    logic [NumCounters-1:0]  ovf_set_s;
    logic [31:0]             rdata_s;
    logic                    unused_wdata_s;

    assign unused_wdata_s = ^reg_wdata_i;

    // Register-port decode into per-counter and global write strobes
    always_comb begin
        wr_s        = reg_valid_i & reg_write_i;
        rd_s        = reg_valid_i & ~reg_write_i;
        global_wr_s = wr_s & (reg_addr_i == GlobalAddr);
        snap_trig_s = global_wr_s & reg_wdata_i[0];
        clr_all_s   = global_wr_s & reg_wdata_i[1];
        clr_ovf_s   = global_wr_s & reg_wdata_i[2];
        for (int k = 0; k < NumCounters; k++) begin
            addr_hit_s[k] = (reg_addr_i[7:2] == 6'(k));
            cfg_we_s[k]   = wr_s & addr_hit_s[k] & (reg_addr_i[1:0] == 2'd0);
            mask_we_s[k]  = wr_s & addr_hit_s[k] & (reg_addr_i[1:0] == 2'd1);
            value_we_s[k] = wr_s & addr_hit_s[k] & (reg_addr_i[1:0] == 2'd2);
        end
    end

    // Per-counter increment: popcount of masked harts raising the selected event
    always_comb begin
        for (int k = 0; k < NumCounters; k++) begin
            inc_s[k] = {IncWidth{1'b0}};
            for (int e = 0; e < NumEvents; e++) begin
                if (evt_sel_r[k] == 8'(e)) begin
                    for (int c = 0; c < NumCores; c++) begin
                        inc_s[k] = inc_s[k] + IncWidth'(mask_r[k][c] & events_r[c*NumEvents + e]);
                    end
                end else begin
                    inc_s[k] = inc_s[k];
                end
            end
        end
    end

    // Wrap or clamp the sum; the extra sum bit is the carry that flags overflow
    always_comb begin
        for (int k = 0; k < NumCounters; k++) begin
            sum_s[k] = {1'b0, value_r[k]} + SumWidth'(inc_s[k]);
            if (sum_s[k][CounterWidth]) begin
                ovf_set_s[k]   = 1'b1;
                value_nxt_s[k] = sat_r[k] ? {CounterWidth{1'b1}} : sum_s[k][CounterWidth-1:0];
            end else begin
                ovf_set_s[k]   = 1'b0;
                value_nxt_s[k] = sum_s[k][CounterWidth-1:0];
            end
        end
    end

    // Read data mux over the counter blocks and the global status word
    always_comb begin
        rdata_s = 32'h0000_0000;
        for (int k = 0; k < NumCounters; k++) begin
            if (addr_hit_s[k]) begin
                case (reg_addr_i[1:0])
                    2'd0:    rdata_s = {16'h0000, evt_sel_r[k], 5'h00, irq_en_r[k], sat_r[k], en_r[k]};
                    2'd1:    rdata_s = 32'(mask_r[k]);
                    2'd2:    rdata_s = 32'(value_r[k]);
                    2'd3:    rdata_s = 32'(snap_r[k]);
                    default: rdata_s = 32'h0000_0000;
                endcase
            end else begin
                rdata_s = rdata_s;
            end
        end
        if (reg_addr_i == GlobalAddr) begin
            rdata_s = 32'(ovf_r);
        end else begin
            rdata_s = rdata_s;
        end
    end

    // Single register stage on the incoming event strobes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            events_r <= {NumEvtBits{1'b0}};
        end else begin
            events_r <= events_i;
        end
    end

    // Per-counter configuration registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            en_r     <= {NumCounters{1'b0}};
            sat_r    <= {NumCounters{1'b0}};
            irq_en_r <= {NumCounters{1'b0}};
            for (int k = 0; k < NumCounters; k++) begin
                evt_sel_r[k] <= 8'h00;
                mask_r[k]    <= {NumCores{1'b0}};
            end
        end else begin
            for (int k = 0; k < NumCounters; k++) begin
                if (cfg_we_s[k]) begin
                    en_r[k]      <= reg_wdata_i[0];
                    sat_r[k]     <= reg_wdata_i[1];
                    irq_en_r[k]  <= reg_wdata_i[2];
                    evt_sel_r[k] <= reg_wdata_i[15:8];
                end
                if (mask_we_s[k]) begin
                    mask_r[k] <= reg_wdata_i[NumCores-1:0];
                end
            end
        end
    end

    // Counter values, snapshots and sticky overflow; a register write or clear drops the increment
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_r <= {NumCounters{1'b0}};
            for (int k = 0; k < NumCounters; k++) begin
                value_r[k] <= {CounterWidth{1'b0}};
                snap_r[k]  <= {CounterWidth{1'b0}};
            end
        end else begin
            for (int k = 0; k < NumCounters; k++) begin
                if (value_we_s[k]) begin
                    value_r[k] <= reg_wdata_i[CounterWidth-1:0];
                end else if (clr_all_s) begin
                    value_r[k] <= {CounterWidth{1'b0}};
                end else if (en_r[k]) begin
                    value_r[k] <= value_nxt_s[k];
                end
                if (snap_trig_s) begin
                    snap_r[k] <= value_r[k];
                end
                ovf_r[k] <= (ovf_r[k] & ~clr_ovf_s)
                          | (en_r[k] & ovf_set_s[k] & ~value_we_s[k] & ~clr_all_s);
            end
        end
    end

    // Read response, interrupt and their reset behaviour
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_r <= 1'b0;
            rdata_r  <= 32'h0000_0000;
            irq_r    <= 1'b0;
        end else begin
            rvalid_r <= rd_s;
            if (rd_s) begin
                rdata_r <= rdata_s;
            end
            irq_r <= |(ovf_r & irq_en_r);
        end
    end

    assign reg_ready_o  = 1'b1;
    assign reg_rvalid_o = rvalid_r;
    assign reg_rdata_o  = rdata_r;
    assign irq_o        = irq_r;

endmodule

// File: tb/tb_snitch_event_counter_bank.sv
// Bench for snitch_event_counter_bank: a 32-bit and an 8-bit instance share the same stimulus
// and are compared every cycle against a behavioural model of the counter bank.
module tb_snitch_event_counter_bank;
    localparam int NC = 8;
    localparam int NE = 7;
    localparam int NK = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [55:0] ev;
    logic        valid;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic        ready_a, rvalid_a, irq_a;
    logic        ready_b, rvalid_b, irq_b;
    logic [31:0] rdata_a, rdata_b;

    int n_err = 0;
    int n_checks = 0;

    // model state; configuration is shared, values differ by width
    int          width_m [2] = '{32, 8};
    bit          m_en [NK], m_sat [NK], m_ie [NK];
    logic [7:0]  m_sel [NK];
    logic [7:0]  m_mask [NK];
    longint      m_val [2][NK];
    longint      m_snap [2][NK];
    bit          m_ovf [2][NK];
    bit          m_irq [2];
    bit          m_rv;
    logic [31:0] m_rd [2];
    logic [55:0] m_pipe;

    snitch_event_counter_bank #(.NumCores(NC), .NumEvents(NE), .NumCounters(NK), .CounterWidth(32)) dut_w32 (
        .clk_i(clk), .rst_i(rst), .events_i(ev), .reg_valid_i(valid), .reg_ready_o(ready_a),
        .reg_write_i(wr), .reg_addr_i(addr), .reg_wdata_i(wdata), .reg_rvalid_o(rvalid_a),
        .reg_rdata_o(rdata_a), .irq_o(irq_a));

    snitch_event_counter_bank #(.NumCores(NC), .NumEvents(NE), .NumCounters(NK), .CounterWidth(8)) dut_w8 (
        .clk_i(clk), .rst_i(rst), .events_i(ev), .reg_valid_i(valid), .reg_ready_o(ready_b),
        .reg_write_i(wr), .reg_addr_i(addr), .reg_wdata_i(wdata), .reg_rvalid_o(rvalid_b),
        .reg_rdata_o(rdata_b), .irq_o(irq_b));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [55:0] evs(input int e, input logic [7:0] harts);
        logic [55:0] v = 56'h0;
        for (int c = 0; c < NC; c++) if (harts[c]) v[c*NE + e] = 1'b1;
        return v;
    endfunction

    function automatic logic [31:0] mread(input int i, input logic [7:0] a);
        int k = int'(a) / 4;
        int r = int'(a) % 4;
        logic [31:0] d = 32'h0;
        if (int'(a) < 4*NK) begin
            if (r == 0) d = {16'h0, m_sel[k], 5'h0, m_ie[k], m_sat[k], m_en[k]};
            else if (r == 1) d = 32'(m_mask[k]);
            else if (r == 2) d = 32'(m_val[i][k]);
            else d = 32'(m_snap[i][k]);
        end else if (int'(a) == 4*NK) begin
            for (int j = 0; j < NK; j++) d[j] = m_ovf[i][j];
        end
        return d;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied
    task automatic model_edge();
        bit     g;
        int     inc [NK];
        longint maxv, sum;
        if (rst) begin
            for (int k = 0; k < NK; k++) begin
                m_en[k] = 0; m_sat[k] = 0; m_ie[k] = 0; m_sel[k] = 8'h0; m_mask[k] = 8'h0;
                for (int i = 0; i < 2; i++) begin
                    m_val[i][k] = 0; m_snap[i][k] = 0; m_ovf[i][k] = 0;
                end
            end
            m_irq = '{0, 0}; m_rv = 0; m_rd = '{32'h0, 32'h0}; m_pipe = 56'h0;
            return;
        end
        m_rv = valid && !wr;
        for (int i = 0; i < 2; i++) begin
            if (m_rv) m_rd[i] = mread(i, addr);
            m_irq[i] = 0;
            for (int k = 0; k < NK; k++) if (m_ovf[i][k] && m_ie[k]) m_irq[i] = 1;
        end
        g = valid && wr && int'(addr) == 4*NK;
        for (int k = 0; k < NK; k++) begin
            inc[k] = 0;
            if (int'(m_sel[k]) < NE)
                for (int c = 0; c < NC; c++)
                    if (m_mask[k][c] && m_pipe[c*NE + int'(m_sel[k])]) inc[k]++;
        end
        for (int i = 0; i < 2; i++) begin
            maxv = (longint'(1) << width_m[i]) - 1;
            for (int k = 0; k < NK; k++) begin
                if (g && wdata[0]) m_snap[i][k] = m_val[i][k];
                if (g && wdata[2]) m_ovf[i][k] = 0;
                if (valid && wr && int'(addr) == 4*k + 2) begin
                    m_val[i][k] = longint'(wdata) & maxv;
                end else if (g && wdata[1]) begin
                    m_val[i][k] = 0;
                end else if (m_en[k]) begin
                    sum = m_val[i][k] + inc[k];
                    if (sum > maxv) begin
                        m_ovf[i][k] = 1;
                        m_val[i][k] = m_sat[k] ? maxv : sum - (maxv + 1);
                    end else begin
                        m_val[i][k] = sum;
                    end
                end
            end
        end
        for (int k = 0; k < NK; k++) begin
            if (valid && wr && int'(addr) == 4*k) begin
                m_en[k] = wdata[0]; m_sat[k] = wdata[1]; m_ie[k] = wdata[2]; m_sel[k] = wdata[15:8];
            end
            if (valid && wr && int'(addr) == 4*k + 1) m_mask[k] = wdata[7:0];
        end
        m_pipe = ev;
    endtask

    // One clock cycle: apply inputs, step the model, check both instances after the edge
    task automatic cyc(input bit r, input logic [55:0] e, input bit v, input bit w,
                       input logic [7:0] a, input logic [31:0] d);
        rst = r; ev = e; valid = v; wr = w; addr = a; wdata = d;
        model_edge();
        @(posedge clk);
        #1;
        check("rvalid_w32", 32'(rvalid_a), 32'(m_rv));
        check("rvalid_w8", 32'(rvalid_b), 32'(m_rv));
        check("irq_w32", 32'(irq_a), 32'(m_irq[0]));
        check("irq_w8", 32'(irq_b), 32'(m_irq[1]));
        if (m_rv) begin
            check($sformatf("rdata_w32_a%0d", a), rdata_a, m_rd[0]);
            check($sformatf("rdata_w8_a%0d", a), rdata_b, m_rd[1]);
        end
    endtask

    task automatic idle(input int n, input logic [55:0] e);
        for (int j = 0; j < n; j++) cyc(1'b0, e, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    task automatic wreg(input logic [7:0] a, input logic [31:0] d, input logic [55:0] e);
        cyc(1'b0, e, 1'b1, 1'b1, a, d);
    endtask

    task automatic rreg(input logic [7:0] a, input logic [55:0] e);
        cyc(1'b0, e, 1'b1, 1'b0, a, 32'h0);
    endtask

    initial begin
        logic [55:0] s3;
        logic [55:0] all3;
        logic [55:0] r_ev;
        logic [31:0] r_d;
        int          first_nz;
        int          op;
        int          k;

        s3   = evs(3, 8'b0010_0101);
        all3 = evs(3, 8'hFF);

        // reset state
        cyc(1'b1, 56'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        cyc(1'b1, 56'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        check("reset_rvalid", 32'(rvalid_a), 32'h0);
        check("reset_rdata", rdata_a, 32'h0);
        check("reset_irq", 32'(irq_a), 32'h0);
        check("ready_tied", 32'(ready_a & ready_b), 32'h1);
        for (int a = 0; a <= 16; a++) begin
            rreg(8'(a), 56'h0);
            check("reset_reg_zero", rdata_a | rdata_b, 32'h0);
        end

        // counting and latency: retired_instr on harts 0,2,5
        wreg(8'd0, 32'h0000_0301, 56'h0);
        wreg(8'd1, 32'h0000_00FF, 56'h0);
        first_nz = -1;
        for (int j = 0; j < 10; j++) begin
            rreg(8'd2, s3);
            if (first_nz < 0 && rdata_a != 32'h0) first_nz = j;
        end
        check("first_nonzero_latency", 32'(first_nz), 32'd2);
        idle(2, 56'h0);
        rreg(8'd2, 56'h0);
        check("count30_w32", rdata_a, 32'd30);
        check("count30_w8", rdata_b, 32'd30);

        // wrap overflow with interrupt
        wreg(8'd0, 32'h0000_0305, 56'h0);
        wreg(8'd2, 32'h0000_00FE, 56'h0);
        idle(1, s3);
        idle(1, 56'h0);
        rreg(8'd2, 56'h0);
        check("wrap_value_w8", rdata_b, 32'h01);
        check("wrap_value_w32", rdata_a, 32'h101);
        check("wrap_irq_w8", 32'(irq_b), 32'h1);
        rreg(8'd16, 56'h0);
        check("wrap_ovf_w8", rdata_b, 32'h1);
        check("wrap_ovf_w32", rdata_a, 32'h0);
        wreg(8'd16, 32'h4, 56'h0);
        idle(2, 56'h0);
        check("irq_cleared_w8", 32'(irq_b), 32'h0);

        // saturation
        wreg(8'd0, 32'h0000_0303, 56'h0);
        wreg(8'd2, 32'h0000_00FD, 56'h0);
        idle(2, all3);
        idle(2, 56'h0);
        rreg(8'd2, 56'h0);
        check("sat_value_w8", rdata_b, 32'hFF);
        check("sat_value_w32", rdata_a, 32'h10D);
        rreg(8'd16, 56'h0);
        check("sat_ovf_w8", rdata_b, 32'h1);
        idle(1, all3);
        idle(2, 56'h0);
        rreg(8'd2, 56'h0);
        check("sat_hold_w8", rdata_b, 32'hFF);
        wreg(8'd16, 32'h4, 56'h0);

        // snapshot atomicity with four active counters
        for (int j = 0; j < NK; j++) begin
            wreg(8'(4*j), 32'(32'h1 | (j << 8)), 56'h0);
            wreg(8'(4*j + 1), 32'(8'h11 << j), 56'h0);
        end
        for (int j = 0; j < 40; j++) begin
            r_ev = 56'({$urandom, $urandom});
            if (j == 12) wreg(8'd16, 32'h1, r_ev);
            else rreg(8'($urandom_range(0, 16)), r_ev);
        end
        for (int j = 0; j < NK; j++) rreg(8'(4*j + 3), 56'({$urandom, $urandom}));

        // collision: VALUE write beats a same-cycle increment of 4
        wreg(8'd4, 32'h0000_0301, all3);
        wreg(8'd5, 32'h0000_000F, all3);
        idle(2, all3);
        wreg(8'd6, 32'h0000_0100, all3);
        rreg(8'd6, all3);
        check("collide_write_wins", rdata_a, 32'h100);
        rreg(8'd6, all3);
        check("collide_next_inc", rdata_a, 32'h104);

        // out-of-range event select never counts
        wreg(8'd8, 32'h0000_C801, 56'h0);
        wreg(8'd9, 32'h0000_00FF, 56'h0);
        wreg(8'd10, 32'h0000_0055, 56'h0);
        idle(5, {56{1'b1}});
        rreg(8'd10, 56'h0);
        check("sel200_frozen", rdata_a, 32'h55);

        // unmapped read, SNAP write ignored, reset behind a read
        rreg(8'h80, 56'h0);
        check("unmapped_rvalid", 32'(rvalid_a), 32'h1);
        check("unmapped_zero", rdata_a, 32'h0);
        wreg(8'd11, 32'h0000_DEAD, 56'h0);
        rreg(8'd11, 56'h0);
        rreg(8'd2, 56'h0);
        cyc(1'b1, 56'h0, 1'b0, 1'b0, 8'h00, 32'h0);
        check("reset_drops_rvalid", 32'(rvalid_a), 32'h0);
        for (int a = 0; a <= 16; a++) begin
            rreg(8'(a), 56'h0);
            check("post_reset_zero", rdata_a | rdata_b, 32'h0);
        end

        // randomized traffic against the model
        for (int j = 0; j < 1500; j++) begin
            r_ev = 56'({$urandom, $urandom}) & 56'({$urandom, $urandom});
            op = $urandom_range(0, 19);
            k = $urandom_range(0, NK - 1);
            r_d = $urandom;
            if (op < 6) begin
                rreg((op == 0) ? 8'($urandom_range(17, 255)) : 8'($urandom_range(0, 16)), r_ev);
            end else if (op < 8) begin
                r_d[15:8] = 8'($urandom_range(0, 8));
                wreg(8'(4*k), r_d, r_ev);
            end else if (op == 8) begin
                wreg(8'(4*k + 1), r_d, r_ev);
            end else if (op == 9) begin
                if (r_d[31]) r_d = 32'hFFFF_FFF0 | {28'h0, r_d[3:0]};
                wreg(8'(4*k + 2 + (op & 0)), r_d, r_ev);
            end else if (op == 10) begin
                wreg(8'(4*k + 3), r_d, r_ev);
            end else if (op == 11) begin
                wreg(8'd16, {29'h0, r_d[2:0]}, r_ev);
            end else if (op == 12 && $urandom_range(0, 30) == 0) begin
                cyc(1'b1, r_ev, 1'b1, 1'b0, 8'd2, 32'h0);
            end else begin
                idle(1, r_ev);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
